// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability counter: level follows a once it has held for STABLE_CYCLES samples.
// Define INPUT_DEBOUNCER_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic level,
  output logic rise,
  output logic fall
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
      $error("input_debouncer: STABLE_CYCLES must be in 1..65535");
    end
    if (GLITCH_W < 1) begin : g_bad_glitch_w
      $error("input_debouncer: GLITCH_W must be at least 1");
    end
  endgenerate

  logic             s0_q, s1_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep s0_q -> s1_q a genuine two-stage shift.
      s0_q    <= a;
      s1_q    <= s0_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin : next_state
    // NOTE: every signal gets a default first so no latch is inferred.
    commit  = 1'b0;
    cnt_d   = '0;
    level_d = level_q;
    if (s1_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        commit  = 1'b1;
        level_d = s1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin : strobe_out
    rise_d = commit & s1_q;
    fall_d = commit & ~s1_q;
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  typedef enum logic {STABLE, PENDING} state_e;

  state_e              state;
  logic                glitch;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  // A PENDING run that meets a matching sample is an aborted transition.
  assign state    = (cnt_q == '0) ? STABLE : PENDING;
  assign glitch   = (s1_q == level_q) && (state == PENDING);
  assign glitch_d = (glitch && (glitch_q != '1)) ? glitch_q + 1'b1 : glitch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_q <= '0;
    else     glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer: three instances share one input and are
// compared every cycle against a sample-window reference model.
module tb_input_debouncer;

  localparam int NM = 3;

  logic clk = 1'b0;
  logic rst;
  logic a;
  logic level0, rise0, fall0;
  logic level1, rise1, fall1;
  logic level2, rise2, fall2;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] gc0;
  logic [1:0] gc1;
  logic [7:0] gc2;
`endif

  always #5 clk = ~clk;

  input_debouncer #(.STABLE_CYCLES(4), .GLITCH_W(8)) dut0 (
    .clk(clk), .rst(rst), .a(a), .level(level0), .rise(rise0), .fall(fall0)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_cnt(gc0)
`endif
  );

  input_debouncer #(.STABLE_CYCLES(4), .GLITCH_W(2)) dut1 (
    .clk(clk), .rst(rst), .a(a), .level(level1), .rise(rise1), .fall(fall1)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_cnt(gc1)
`endif
  );

  input_debouncer #(.STABLE_CYCLES(1), .GLITCH_W(8)) dut2 (
    .clk(clk), .rst(rst), .a(a), .level(level2), .rise(rise2), .fall(fall2)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_cnt(gc2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: a value of a sampled at edge e reaches the debounce logic at edge e+2.
  // A commit happens when the last S samples all disagree with level and all lie after the
  // previous commit; an abort is an agreeing sample right after an uncommitted disagreeing one.
  logic hist[$];
  int   n_edges;
  logic m_level[NM];
  logic m_rise[NM];
  logic m_fall[NM];
  int   m_last[NM];
  int   m_gl[NM];
  int   rise0_cnt = 0;
  int   fall0_cnt = 0;

  function automatic int sc_of(input int m);
    return (m == 2) ? 1 : 4;
  endfunction

  function automatic int gmax_of(input int m);
    return (m == 1) ? 3 : 255;
  endfunction

  function automatic logic s1_at(input int e);
    return (e >= 2) ? hist[e-2] : 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_edges = 0;
    for (int m = 0; m < NM; m++) begin
      m_level[m] = 1'b0;
      m_rise[m]  = 1'b0;
      m_fall[m]  = 1'b0;
      m_last[m]  = -1;
      m_gl[m]    = 0;
    end
  endtask

  task automatic model_edge(input logic av);
    hist.push_back(av);
    for (int m = 0; m < NM; m++) begin
      logic v;
      bit   run;
      int   s;
      s = sc_of(m);
      v = s1_at(n_edges);
      m_rise[m] = 1'b0;
      m_fall[m] = 1'b0;
      if (v != m_level[m]) begin
        run = (n_edges - s + 1) > m_last[m];
        for (int j = 0; j < s; j++)
          if (s1_at(n_edges - j) != v) run = 1'b0;
        if (run) begin
          m_level[m] = v;
          m_rise[m]  = v;
          m_fall[m]  = !v;
          m_last[m]  = n_edges;
        end
      end else if ((n_edges - 1) > m_last[m] && s1_at(n_edges - 1) != m_level[m]) begin
        if (m_gl[m] < gmax_of(m)) m_gl[m]++;
      end
    end
    n_edges++;
  endtask

  task automatic cmp_one(input int m, input logic l, input logic r, input logic f);
    check($sformatf("level[%0d]", m), l, m_level[m]);
    check($sformatf("rise[%0d]", m), r, m_rise[m]);
    check($sformatf("fall[%0d]", m), f, m_fall[m]);
    check($sformatf("excl[%0d]", m), r & f, 0);
  endtask

  task automatic compare_all();
    cmp_one(0, level0, rise0, fall0);
    cmp_one(1, level1, rise1, fall1);
    cmp_one(2, level2, rise2, fall2);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("glitch[0]", gc0, m_gl[0]);
    check("glitch[1]", gc1, m_gl[1]);
    check("glitch[2]", gc2, m_gl[2]);
`endif
    if (rise0) rise0_cnt++;
    if (fall0) fall0_cnt++;
  endtask

  // Called at a falling edge; drives a, lets one rising edge pass, checks at the next falling edge.
  task automatic step(input logic av);
    a = av;
    @(posedge clk);
    model_edge(av);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic av, input int cycles);
    for (int i = 0; i < cycles; i++) step(av);
  endtask

  // Asserts rst mid-period and checks that outputs clear before any clock edge.
  task automatic do_reset(input logic a_after);
    #2 rst = 1'b1;
    #1;
    check("rst_level0", level0, 0);
    check("rst_rise0", rise0, 0);
    check("rst_fall0", fall0, 0);
    check("rst_level1", level1, 0);
    check("rst_level2", level2, 0);
    check("rst_strobes", {rise1, fall1, rise2, fall2}, 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("rst_glitch", {gc0, gc1, gc2}, 0);
`endif
    model_reset();
    a = a_after;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r0;
    int f0;
    rst = 1'b1;
    a   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("por_level0", level0, 0);
    check("por_strobes0", {rise0, fall0}, 0);
    rst = 1'b0;

    // Reset values held with a low.
    hold(1'b0, 10);
    check("t1_level0", level0, 0);
    check("t1_strobes0", {rise0, fall0}, 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("t1_glitch0", gc0, 0);
`endif

    // Clean rise then clean fall: strobe on the sixth edge after the change is first sampled.
    r0 = rise0_cnt;
    f0 = fall0_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check($sformatf("t2_rise_e%0d", i), rise0, (i == 5));
    end
    check("t2_level_hi", level0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      check($sformatf("t2_fall_e%0d", i), fall0, (i == 5));
    end
    check("t2_rise_count", rise0_cnt - r0, 1);
    check("t2_fall_count", fall0_cnt - f0, 1);

    // Short pulse never reaches level.
    r0 = rise0_cnt;
    hold(1'b1, 3);
    hold(1'b0, 8);
    check("t3_level", level0, 0);
    check("t3_rise_count", rise0_cnt - r0, 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("t3_glitch0", gc0, 1);
`endif

    // Bounce on release.
    do_reset(1'b0);
    hold(1'b1, 8);
    f0 = fall0_cnt;
    hold(1'b0, 2);
    step(1'b1);
    check("t4_no_fall_bounce", fall0_cnt - f0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      check($sformatf("t4_fall_e%0d", i), fall0, (i == 5));
    end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("t4_glitch0", gc0, 1);
`endif

    // Saturating 2-bit glitch counter.
    do_reset(1'b0);
    for (int p = 0; p < 6; p++) begin
      hold(1'b1, 2);
      hold(1'b0, 4);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
      check($sformatf("t5_glitch_sat_p%0d", p), gc1, (p < 2) ? p + 1 : 3);
`endif
    end

    // One-cycle window: a one-cycle pulse gives level high for exactly one cycle.
    for (int i = 0; i < 5; i++) begin
      step(i == 0);
      check($sformatf("t5_w1_level_%0d", i), level2, (i == 2));
      check($sformatf("t5_w1_rise_%0d", i), rise2, (i == 2));
      check($sformatf("t5_w1_fall_%0d", i), fall2, (i == 3));
    end

    // Reset while a fall is pending, then a held high after release.
    hold(1'b1, 8);
    check("t6_level_before", level0, 1);
    hold(1'b0, 4);
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check($sformatf("t6_rise_e%0d", i), rise0, (i == 5));
    end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("t6_glitch0", gc0, 0);
`endif

    // Random segments with occasional mid-run resets.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 29) == 0) do_reset(1'($urandom_range(0, 1)));
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
